// File: rtl/edabk_tx_buffer.sv
// Host-side FIFO feeding edabk_transmitter one frame at a time on bclk.
// Optional watchdog on the WAIT state: define EDABK_TX_BUFFER_WATCHDOG_EN.
module edabk_tx_buffer #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_WIDTH     = $clog2(FIFO_DEPTH),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  bclk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_finish,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  tx_timeout,
  output logic [1:0]            dbg_state
);

  // Handshake: a word moves on a rising bclk edge where wr_valid && wr_ready;
  // wr_ready is !full and does not look at wr_valid or at a same-cycle pop.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1))
  begin : g_cfg_check
    $error("edabk_tx_buffer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = wr_valid && !w_full;

`ifdef EDABK_TX_BUFFER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_tx_timeout;
  logic            w_expire;
`endif

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
`ifdef EDABK_TX_BUFFER_WATCHDOG_EN
    w_expire = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        // A finish landing on the expiry cycle counts as normal completion.
        if (tx_finish) begin
          w_next = S_IDLE;
        end
`ifdef EDABK_TX_BUFFER_WATCHDOG_EN
        else if (r_wd_cnt == WD_LAST) begin
          w_expire = 1'b1;
          w_next   = S_IDLE;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state <= w_next;
      // Start pulse is the registered image of LAUNCH: high in the first WAIT cycle.
      r_tx_start <= (r_state == S_LAUNCH);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge bclk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

`ifdef EDABK_TX_BUFFER_WATCHDOG_EN
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt     <= '0;
      r_tx_timeout <= 1'b0;
    end else begin
      r_tx_timeout <= w_expire;
      if (r_state == S_LAUNCH) r_wd_cnt <= '0;
      else if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign tx_timeout = r_tx_timeout;
`else
  assign tx_timeout = 1'b0;
`endif

  assign wr_ready  = !w_full;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule
